// File: rtl/axi_sram_slave_if.sv
// AXI4 channel bundle (8-bit IDs, 32-bit address and data) with slave and master views.
// Signal names follow the AXI channel naming so traces read directly against the protocol.
interface AXI_interface_slave;
  logic [7:0]  AWID;
  logic [31:0] AWADDR;
  logic [3:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;

  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;

  logic [7:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;

  logic [7:0]  ARID;
  logic [31:0] ARADDR;
  logic [3:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;

  logic [7:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 INCR-burst responder onto one single-port SRAM; one transaction at a time, reads 2 cycles/beat.
// Writes land in the W handshake cycle; R/B are held until RREADY/BREADY, W is accepted only in WR.
module axi_sram_slave #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  AXI_interface_slave.slave     s,
  output logic                  CEB,
  output logic                  WEB,
  output logic [DATA_WIDTH-1:0] BWEB,
  output logic [ADDR_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] DI,
  input  logic [DATA_WIDTH-1:0] DO
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ACC  = 3'd1,
    RD_DATA = 3'd2,
    WR      = 3'd3,
    WR_RESP = 3'd4
  } state_t;

  typedef struct packed {
    logic [7:0] id;
    logic [3:0] len;
  } txn_t;

  state_t                state;
  state_t                state_nxt;
  txn_t                  txn;
  logic [ADDR_WIDTH-1:0] addr;
  logic [3:0]            cnt;
  logic                  rd_prio;
  logic                  rd_first;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  ar_rdy;
  logic                  aw_rdy;
  logic                  w_rdy;
  logic                  r_vld;
  logic                  b_vld;
  logic                  ceb;
  logic                  web;
  logic [DATA_WIDTH-1:0] bweb;
  logic [DATA_WIDTH-1:0] di;

  logic                  ar_hs;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  r_hs;
  logic                  b_hs;
  logic                  last_beat;

  assign ar_hs     = ar_rdy;
  assign aw_hs     = aw_rdy;
  assign w_hs      = w_rdy & s.WVALID;
  assign r_hs      = r_vld & s.RREADY;
  assign b_hs      = b_vld & s.BREADY;
  assign last_beat = (cnt == txn.len);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (ar_hs) begin
          state_nxt = RD_ACC;
        end else if (aw_hs) begin
          state_nxt = WR;
        end
      end
      RD_ACC:  state_nxt = RD_DATA;
      RD_DATA: begin
        if (r_hs) begin
          state_nxt = last_beat ? IDLE : RD_ACC;
        end
      end
      WR: begin
        if (w_hs && s.WLAST) begin
          state_nxt = WR_RESP;
        end
      end
      WR_RESP: begin
        if (b_hs) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Everything is gated by rst so the bus and macro are quiet even before the first reset edge.
  always_comb begin
    ar_rdy = 1'b0;
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    r_vld  = 1'b0;
    b_vld  = 1'b0;
    ceb    = 1'b1;
    web    = 1'b1;
    bweb   = '1;
    di     = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          ar_rdy = s.ARVALID & (~s.AWVALID | rd_prio);
          aw_rdy = s.AWVALID & ~ar_rdy;
        end
        RD_ACC:  ceb = 1'b0;
        RD_DATA: r_vld = 1'b1;
        WR: begin
          w_rdy = 1'b1;
          if (s.WVALID) begin
            ceb = 1'b0;
            web = 1'b0;
            di  = s.WDATA;
            for (int i = 0; i < DATA_WIDTH / 8; i++) begin
              bweb[8*i +: 8] = {8{~s.WSTRB[i]}};
            end
          end
        end
        WR_RESP: b_vld = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_prio  <= 1'b1;
      rd_first <= 1'b0;
      rdata_q  <= '0;
      addr     <= '0;
      cnt      <= '0;
      txn      <= '0;
    end else begin
      rd_first <= (state == RD_ACC);
      if (rd_first) begin
        rdata_q <= DO;
      end
      if (ar_hs) begin
        addr    <= s.ARADDR[ADDR_WIDTH+1:2];
        txn.id  <= s.ARID;
        txn.len <= s.ARLEN;
        cnt     <= '0;
        rd_prio <= 1'b0;
      end else if (aw_hs) begin
        addr    <= s.AWADDR[ADDR_WIDTH+1:2];
        txn.id  <= s.AWID;
        txn.len <= s.AWLEN;
        cnt     <= '0;
        rd_prio <= 1'b1;
      end else if (r_hs && !last_beat) begin
        addr <= addr + ADDR_WIDTH'(1);
        cnt  <= cnt + 4'd1;
      end else if (w_hs) begin
        addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

  // The macro presents DO only in the first RD_DATA cycle's window; the register keeps it stable across stalls.
  assign s.ARREADY = ar_rdy;
  assign s.AWREADY = aw_rdy;
  assign s.WREADY  = w_rdy;
  assign s.RVALID  = r_vld;
  assign s.RDATA   = r_vld ? (rd_first ? DO : rdata_q) : '0;
  assign s.RID     = r_vld ? txn.id : 8'd0;
  assign s.RLAST   = r_vld & last_beat;
  assign s.RRESP   = 2'b00;
  assign s.BVALID  = b_vld;
  assign s.BID     = b_vld ? txn.id : 8'd0;
  assign s.BRESP   = 2'b00;

  assign CEB  = ceb;
  assign WEB  = web;
  assign BWEB = bweb;
  assign DI   = di;
  assign A    = rst ? '0 : addr;

  logic unused_bits;
  assign unused_bits = ^{s.AWSIZE, s.AWBURST, s.ARSIZE, s.ARBURST,
                         s.AWADDR[31:ADDR_WIDTH+2], s.AWADDR[1:0],
                         s.ARADDR[31:ADDR_WIDTH+2], s.ARADDR[1:0]};

endmodule
